uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_drain.sv | 138 +++++++++++++
 tb/tb_uart_tx_drain.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity
// encodings and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: strobes tick on the last cycle of every bit period,
// held at zero while clear is high so the first bit gets a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a read-latency-1 buffer: fetches one word,
// serialises it as start/data/parity/stop, and repeats while enabled.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_valid,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 underrun
);

  localparam int unsigned IW = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_idx;
  logic                 bit_tick;
  logic                 baud_clear;

  // The bit timer only runs while a frame is on the line.
  assign baud_clear = (state == S_IDLE) || (state == S_FETCH) || (state == S_WAIT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      underrun   <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_idx   <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      tx_done    <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en && !fifo_empty) begin
            state      <= S_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo_rd_valid) begin
            shreg   <= fifo_rd_data;
            par_bit <= (^fifo_rd_data) ^ (PARITY == PAR_ODD);
            state   <= S_START;
            txd     <= 1'b0;
          end else begin
            underrun <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                state <= S_PARITY;
                txd   <= par_bit;
              end else begin
                state    <= S_STOP;
                txd      <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            state    <= S_STOP;
            txd      <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4: frame shape, parity,
// back-to-back draining, underrun, async reset and tx_en gating.
module tb_uart_tx_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       tx_en = 1'b0, fifo_empty = 1'b1, fifo_rd_valid = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_en, txd, busy, tx_done, underrun;

  logic       p_tx_en = 1'b0, p_empty = 1'b1, p_valid = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       pe_rd_en, pe_txd, pe_busy, pe_done, pe_urun;
  logic       po_rd_en, po_txd, po_busy, po_done, po_urun;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       starve = 1'b0, glitch_valid = 1'b0, txd_low = 1'b0;
  int         rd_en_cnt = 0, done_cnt = 0, urun_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_valid(fifo_rd_valid), .fifo_rd_data(fifo_rd_data),
    .txd(txd), .busy(busy), .tx_done(tx_done), .underrun(underrun)
  );

  uart_tx_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_en(p_tx_en), .fifo_empty(p_empty),
    .fifo_rd_en(pe_rd_en), .fifo_rd_valid(p_valid), .fifo_rd_data(p_data),
    .txd(pe_txd), .busy(pe_busy), .tx_done(pe_done), .underrun(pe_urun)
  );

  uart_tx_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_en(p_tx_en), .fifo_empty(p_empty),
    .fifo_rd_en(po_rd_en), .fifo_rd_valid(p_valid), .fifo_rd_data(p_data),
    .txd(po_txd), .busy(po_busy), .tx_done(po_done), .underrun(po_urun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: advance past the edge, then play the buffer's role (data one
  // cycle after an accepted read request) and tally output pulses.
  task automatic step();
    logic rd_pre, prd_pre;
    rd_pre  = fifo_rd_en;
    prd_pre = pe_rd_en;
    @(posedge clk);
    #1;
    if (rd_pre && !starve && q.size() > 0) begin
      fifo_rd_valid = 1'b1;
      fifo_rd_data  = q.pop_front();
      fifo_empty    = (q.size() == 0);
    end else begin
      fifo_rd_valid = glitch_valid;
      fifo_rd_data  = 8'($urandom);
    end
    if (prd_pre) begin
      p_valid = 1'b1;
      p_data  = 8'hA3;
      p_empty = 1'b1;
    end else begin
      p_valid = 1'b0;
      p_data  = 8'($urandom);
    end
    if (fifo_rd_en) rd_en_cnt++;
    if (tx_done)    done_cnt++;
    if (underrun)   urun_cnt++;
    if (!txd)       txd_low = 1'b1;
  endtask

  task automatic clr_counts();
    rd_en_cnt = 0; done_cnt = 0; urun_cnt = 0; txd_low = 1'b0;
  endtask

  // pat[i] is the line level of serial bit i (start, 8 data, stop).
  task automatic run_frame_main(input logic [7:0] d, input logic [9:0] pat, input string name);
    clr_counts();
    q.push_back(d);
    fifo_empty = 1'b0;
    tx_en = 1'b1;
    step();
    chk({name, "_fetch_rd_en"}, fifo_rd_en, 1);
    chk({name, "_fetch_busy"}, busy, 1);
    step();
    chk({name, "_wait_rd_en"}, fifo_rd_en, 0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("%s_txd_cyc%0d", name, k), txd, pat[k/4]);
    end
    step();
    chk({name, "_tx_done"}, tx_done, 1);
    chk({name, "_busy_end"}, busy, 0);
    step();
    chk({name, "_tx_done_pulse"}, tx_done, 0);
    chk({name, "_done_cnt"}, done_cnt, 1);
    chk({name, "_rd_en_cnt"}, rd_en_cnt, 1);
    tx_en = 1'b0;
  endtask

  initial begin
    logic [10:0] even_pat, odd_pat;
    int          gaps[$];
    int          gap;
    logic        in_gap;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_even_txd", pe_txd, 1);
    rst_n = 1'b1;
    repeat (2) step();

    // 0x55, no parity: 0,1,0,1,0,1,0,1,0,1
    run_frame_main(8'h55, 10'h2AA, "f55");

    // 0xA3 with even and odd parity: 0,1,1,0,0,0,1,0,1,P,1
    even_pat = 11'h546;
    odd_pat  = 11'h746;
    p_empty = 1'b0;
    p_tx_en = 1'b1;
    repeat (2) step();
    for (int k = 0; k < 44; k++) begin
      step();
      if (k == 2) p_tx_en = 1'b0;
      chk($sformatf("even_txd_cyc%0d", k), pe_txd, even_pat[k/4]);
      chk($sformatf("odd_txd_cyc%0d", k), po_txd, odd_pat[k/4]);
    end
    step();
    chk("even_tx_done", pe_done, 1);
    chk("odd_tx_done", po_done, 1);

    // Three preloaded bytes drained back to back
    clr_counts();
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56);
    fifo_empty = 1'b0;
    tx_en = 1'b1;
    in_gap = 1'b0;
    gap = 0;
    for (int c = 0; c < 400 && done_cnt < 3; c++) begin
      step();
      if (in_gap) begin
        if (!txd) begin
          gaps.push_back(gap);
          in_gap = 1'b0;
        end else begin
          gap++;
        end
      end
      if (tx_done) begin
        in_gap = 1'b1;
        gap = 1;
      end
    end
    repeat (4) step();
    chk("b2b_rd_en_cnt", rd_en_cnt, 3);
    chk("b2b_done_cnt", done_cnt, 3);
    chk("b2b_gap_cnt", gaps.size(), 2);
    chk("b2b_gap0", (gaps.size() > 0) ? gaps[0] : 0, 3);
    chk("b2b_gap1", (gaps.size() > 1) ? gaps[1] : 0, 3);
    chk("b2b_idle_busy", busy, 0);
    tx_en = 1'b0;

    // Underrun: read requested but no data returned
    clr_counts();
    starve = 1'b1;
    fifo_empty = 1'b0;
    tx_en = 1'b1;
    step();
    chk("ur_fetch_busy", busy, 1);
    step();
    chk("ur_wait_busy", busy, 1);
    step();
    chk("ur_pulse", underrun, 1);
    chk("ur_idle_busy", busy, 0);
    tx_en = 1'b0;
    step();
    chk("ur_pulse_end", underrun, 0);
    chk("ur_cnt", urun_cnt, 1);
    chk("ur_txd_high", txd_low, 0);
    fifo_empty = 1'b1;
    starve = 1'b0;
    glitch_valid = 1'b1;
    repeat (3) step();
    chk("stray_valid_busy", busy, 0);
    chk("stray_valid_txd", txd_low, 0);
    glitch_valid = 1'b0;

    // Asynchronous reset during data bit 3, then recovery
    clr_counts();
    q.push_back(8'h00);
    fifo_empty = 1'b0;
    tx_en = 1'b1;
    repeat (20) step();
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_busy", busy, 1);
    tx_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", txd, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_tx_done", tx_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_done", done_cnt, 0);
    run_frame_main(8'h0F, 10'h21E, "f0f");

    // tx_en dropped during START: frame completes, no further fetch
    clr_counts();
    q.push_back(8'h3C); q.push_back(8'h99);
    fifo_empty = 1'b0;
    tx_en = 1'b1;
    repeat (5) step();
    chk("drop_in_start", txd, 0);
    tx_en = 1'b0;
    for (int c = 0; c < 80 && done_cnt == 0; c++) step();
    chk("drop_done_cnt", done_cnt, 1);
    repeat (10) step();
    chk("drop_rd_en_cnt", rd_en_cnt, 1);
    chk("drop_rd_en_low", fifo_rd_en, 0);
    chk("drop_idle_busy", busy, 0);
    q.delete();
    fifo_empty = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
